// File: rtl/ifid_stage.sv
// IF/ID pipeline register with stall/flush handling and in-flight HALT tracking.
// Optional performance counters are built when IFID_PERF_EN is defined.
module ifid_stage #(
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] if_instr,
    input  logic [15:0] if_pc,
    input  logic [15:0] if_pc_next,
    input  logic        if_err,
    input  logic        stall,
    input  logic        flush,
    input  logic        wb_halt,
    output logic [15:0] id_instr,
    output logic [15:0] id_pc,
    output logic [15:0] id_pc_next,
    output logic        id_valid,
    output logic        id_err,
    output logic        fetch_hold,
    output logic        halted,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, HALT_WAIT, HALTED} state_t;
    state_t state;

    logic load_halt;
    assign load_halt = !flush && !stall && (if_instr[15:11] == HALT_OPC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_instr   <= NOP_INSTR;
            id_pc      <= 16'h0000;
            id_pc_next <= 16'h0000;
            id_valid   <= 1'b0;
            id_err     <= 1'b0;
        end else if (flush) begin
            id_instr   <= NOP_INSTR;
            id_pc      <= if_pc;
            id_pc_next <= if_pc_next;
            id_valid   <= 1'b0;
            id_err     <= 1'b0;
        end else if (!stall) begin
            // Once a HALT is in flight, everything fetched behind it becomes a bubble.
            id_pc      <= if_pc;
            id_pc_next <= if_pc_next;
            if (state != RUN) begin
                id_instr <= NOP_INSTR;
                id_valid <= 1'b0;
                id_err   <= 1'b0;
            end else begin
                id_instr <= if_instr;
                id_valid <= 1'b1;
                id_err   <= if_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            fetch_hold <= 1'b0;
            halted     <= 1'b0;
        end else begin
            case (state)
                RUN: if (load_halt) begin
                    state      <= HALT_WAIT;
                    fetch_hold <= 1'b1;
                end
                // A retired HALT is architectural, so it beats a same-cycle flush.
                HALT_WAIT: if (wb_halt) begin
                    state  <= HALTED;
                    halted <= 1'b1;
                end else if (flush) begin
                    state      <= RUN;
                    fetch_hold <= 1'b0;
                end
                default: begin
                    state      <= HALTED;
                    fetch_hold <= 1'b1;
                    halted     <= 1'b1;
                end
            endcase
        end
    end

`ifdef IFID_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 16'h0000;
            flush_cnt <= 16'h0000;
        end else begin
            if (stall && !flush && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'h0001;
            if (flush && flush_cnt != 16'hFFFF)           flush_cnt <= flush_cnt + 16'h0001;
        end
    end
`else
    assign stall_cnt = 16'h0000;
    assign flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_ifid_stage.sv
// Directed bench for ifid_stage: reset, stall/flush, HALT tracking, error pass-through, counters.
module tb_ifid_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] if_instr = 16'h0000, if_pc = 16'h0000, if_pc_next = 16'h0000;
    logic        if_err = 1'b0, stall = 1'b0, flush = 1'b0, wb_halt = 1'b0;
    logic [15:0] id_instr, id_pc, id_pc_next, stall_cnt, flush_cnt;
    logic        id_valid, id_err, fetch_hold, halted;

    int checks = 0;
    int failures = 0;

    ifid_stage dut (
        .clk(clk), .rst_n(rst_n), .if_instr(if_instr), .if_pc(if_pc), .if_pc_next(if_pc_next),
        .if_err(if_err), .stall(stall), .flush(flush), .wb_halt(wb_halt),
        .id_instr(id_instr), .id_pc(id_pc), .id_pc_next(id_pc_next), .id_valid(id_valid),
        .id_err(id_err), .fetch_hold(fetch_hold), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] instr, input logic [15:0] pc);
        if_instr   = instr;
        if_pc      = pc;
        if_pc_next = pc + 16'd2;
    endtask

    // Asynchronous reset asserted mid-cycle, released just after an edge.
    task automatic do_reset();
        #3 rst_n = 1'b0;
        stall = 0; flush = 0; wb_halt = 0; if_err = 0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset with toggling inputs
        for (int i = 0; i < 4; i++) begin
            drive(16'h1111 * i[15:0], 16'h0100 + i[15:0]);
            if_err = i[0];
            step();
        end
        chk("rst_instr", id_instr, 16'h0800);
        chk("rst_valid", id_valid, 0);
        chk("rst_hold", fetch_hold, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc", id_pc, 0);
        chk("rst_err", id_err, 0);
        chk("rst_scnt", stall_cnt, 0);
        rst_n = 1'b1; if_err = 0;

        drive(16'h4123, 16'h0010);
        step();
        chk("ld_instr", id_instr, 16'h4123);
        chk("ld_pc", id_pc, 16'h0010);
        chk("ld_pcn", id_pc_next, 16'h0012);
        chk("ld_valid", id_valid, 1);

        // Stall holds, flush wins over stall
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive(16'h4567 + i[15:0], 16'h0020);
            step();
            chk("stall_hold", id_instr, 16'h4123);
            chk("stall_pc", id_pc, 16'h0010);
            chk("stall_valid", id_valid, 1);
        end
        flush = 1;
        step();
        chk("sf_instr", id_instr, 16'h0800);
        chk("sf_valid", id_valid, 0);
        stall = 0; flush = 0;

        // Error pass-through
        drive(16'h4123, 16'h0030); if_err = 1;
        step();
        chk("err_set", id_err, 1);
        flush = 1;
        step();
        chk("err_flush", id_err, 0);
        flush = 0; if_err = 0;

        // Halt retire
        drive(16'h0000, 16'h0040);
        step();
        chk("h_instr", id_instr, 16'h0000);
        chk("h_hold", fetch_hold, 1);
        chk("h_valid", id_valid, 1);
        drive(16'h4123, 16'h0042);
        step();
        chk("h_sq_instr", id_instr, 16'h0800);
        chk("h_sq_valid", id_valid, 0);
        chk("h_not_yet", halted, 0);
        step();
        chk("h_sq2", id_instr, 16'h0800);
        wb_halt = 1;
        step();
        wb_halt = 0;
        chk("h_halted", halted, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("h_stay", halted, 1);
            chk("h_bubble", id_valid, 0);
        end
        #3 rst_n = 1'b0;
        #1;
        chk("h_async_halted", halted, 0);
        chk("h_async_hold", fetch_hold, 0);
        chk("h_async_instr", id_instr, 16'h0800);
        step();
        rst_n = 1'b1;

        // Wrong-path halt
        drive(16'h0000, 16'h0050);
        step();
        chk("wp_hold1", fetch_hold, 1);
        drive(16'h4123, 16'h0080); flush = 1;
        step();
        flush = 0;
        chk("wp_hold0", fetch_hold, 0);
        chk("wp_valid0", id_valid, 0);
        step();
        chk("wp_instr", id_instr, 16'h4123);
        chk("wp_valid", id_valid, 1);
        chk("wp_halted", halted, 0);

        // Flush and wb_halt together
        drive(16'h0000, 16'h0060);
        step();
        flush = 1; wb_halt = 1;
        step();
        flush = 0; wb_halt = 0;
        chk("fw_halted", halted, 1);
        chk("fw_valid", id_valid, 0);
        do_reset();

        // HALT under stall is not latched until the load happens
        stall = 1; drive(16'h0000, 16'h0070);
        step();
        chk("sh_hold", fetch_hold, 0);
        chk("sh_instr", id_instr, 16'h0800);
        stall = 0;
        step();
        chk("sh_instr2", id_instr, 16'h0000);
        chk("sh_hold2", fetch_hold, 1);
        do_reset();

        // wb_halt in RUN ignored
        drive(16'h4123, 16'h0090); wb_halt = 1;
        step();
        wb_halt = 0;
        chk("wr_halted", halted, 0);
        chk("wr_hold", fetch_hold, 0);
        chk("wr_valid", id_valid, 1);
        do_reset();

        // Counters: 5 stall cycles, flush on the last, one lone flush
        stall = 1;
        for (int i = 0; i < 5; i++) begin
            flush = (i == 4);
            step();
        end
        stall = 0; flush = 1;
        step();
        flush = 0;
        step();
`ifdef IFID_PERF_EN
        chk("cnt_stall", stall_cnt, 16'd4);
        chk("cnt_flush", flush_cnt, 16'd2);
        stall = 1;
        for (int i = 0; i < 65540; i++) step();
        chk("cnt_sat", stall_cnt, 16'hFFFF);
        step();
        chk("cnt_sat2", stall_cnt, 16'hFFFF);
        chk("cnt_flush_keep", flush_cnt, 16'd2);
        stall = 0;
        do_reset();
        chk("cnt_rst", stall_cnt, 0);
`else
        chk("cnt_stall_off", stall_cnt, 0);
        chk("cnt_flush_off", flush_cnt, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifid_stage.md
# ifid_stage

IF/ID pipeline stage sitting directly downstream of fetch: registers the fetched instruction, its PC and PC+2 into the decode stage. Applies stall (hold) and flush (bubble) requests from the hazard/branch logic, and detects HALT in flight. Drives a fetch-hold back to fetch so the PC freezes once a HALT is latched, until the HALT retires or is squashed.

## Interface
Parameters:
- `NOP_INSTR`, 16'h0800 — bubble encoding inserted on reset, flush and halt squash.
- `HALT_OPC`, 5'b00000 — opcode (instr[15:11]) identifying HALT.

Ports:
- `clk`  in  1  — clock; all state updates on rising edge.
- `rst_n`  in  1  — reset; asynchronous, active-low.
- `if_instr`  in  16  — instruction from fetch.
- `if_pc`  in  16  — PC of `if_instr`.
- `if_pc_next`  in  16  — PC+2 from fetch.
- `if_err`  in  1  — instruction-memory error for `if_instr`.
- `stall`  in  1  — hazard unit: hold ID contents.
- `flush`  in  1  — branch resolved taken: squash ID.
- `wb_halt`  in  1  — HALT retired at writeback (one-cycle pulse).
- `id_instr`  out  16  — registered instruction to decode.
- `id_pc`, `id_pc_next`  out  16 each — registered PC / PC+2.
- `id_valid`  out  1  — ID holds a real (non-bubble) instruction.
- `id_err`  out  1  — registered `if_err` for this entry.
- `fetch_hold`  out  1  — to fetch: do not advance PC.
- `halted`  out  1  — processor halted; asserted until reset.
- `stall_cnt`, `flush_cnt`  out  16 each — performance counters (see Configuration).

## Operation
- Per-cycle update priority: flush > stall > halt squash > load.
- Load: ID regs <= IF inputs; `id_valid`=1, `id_err`=`if_err`.
- Stall (no flush): all ID regs hold, `id_valid` holds.
- Flush: `id_instr`<=`NOP_INSTR`, `id_valid`<=0, `id_err`<=0; PCs load from IF (don't-care for bubbles). Flush during stall: flush wins.
- State machine `RUN`, `HALT_WAIT`, `HALTED`:
  - `RUN`: load of instr with instr[15:11]==`HALT_OPC` (and no flush/stall) -> `HALT_WAIT`.
  - `HALT_WAIT`: `fetch_hold`=1; every subsequent load is squashed to `NOP_INSTR`, `id_valid`=0. `flush` -> `RUN` (HALT was wrong-path), same-cycle flush behaviour applies. `wb_halt` -> `HALTED`. `flush` and `wb_halt` together: `HALTED` (retired HALT is architectural).
  - `HALTED`: `fetch_hold`=1, `halted`=1, ID squashed to bubble; exits only on reset.
- HALT while `stall`: not latched until the stall releases and the load actually occurs.
- `wb_halt` in `RUN` is ignored.

## Timing
- Latency: IF inputs appear on ID outputs one cycle after the capturing edge.
- `fetch_hold` and `halted` are registered (decoded from state); `fetch_hold` rises the cycle HALT appears on `id_instr`.
- Reset values: `id_instr`=`NOP_INSTR`, `id_pc`=`id_pc_next`=0, `id_valid`=0, `id_err`=0, `fetch_hold`=0, `halted`=0, state `RUN`, counters 0.
- `rst_n` low mid-operation: all of the above immediately, asynchronous to `clk`; release takes effect on next edge.

## Configuration
- `IFID_PERF_EN` defined: `stall_cnt` increments each cycle `stall`=1 and `flush`=0; `flush_cnt` increments each cycle `flush`=1; both 16-bit, saturate at 16'hFFFF (no wrap), cleared only by reset.
- `IFID_PERF_EN` undefined: counter logic not built; `stall_cnt`=`flush_cnt`=16'h0000 constant. Port list unchanged.

## Test plan
- Reset: hold `rst_n`=0 with IF inputs toggling -> `id_instr`=16'h0800, `id_valid`=0, `fetch_hold`=0; release, drive `if_instr`=16'h4123, `if_pc`=16'h0010 -> next cycle `id_instr`=16'h4123, `id_pc`=16'h0010, `id_valid`=1.
- Stall/flush: load 16'h4123, then `stall`=1 for 3 cycles with new IF data -> ID holds 16'h4123; assert `stall`=`flush`=1 -> `id_instr`=16'h0800, `id_valid`=0.
- Halt retire: load 16'h0000 -> `fetch_hold`=1 next cycle, following loads of 16'h4123 give bubbles; pulse `wb_halt` -> `halted`=1, stays 1 for 10 cycles; `rst_n` low -> `halted`=0.
- Wrong-path halt: load 16'h0000, then `flush`=1 -> state `RUN`, `fetch_hold`=0 next cycle, next load 16'h4123 passes with `id_valid`=1; also `flush`+`wb_halt` same cycle -> `halted`=1.
- Error pass-through: `if_err`=1 with 16'h4123 -> `id_err`=1 next cycle; flush -> `id_err`=0.
- Counters (`IFID_PERF_EN` defined): 5 stall cycles, 2 flush cycles (one overlapping a stall) -> `stall_cnt`=4, `flush_cnt`=2; preload-force to 16'hFFFF plus stall -> stays 16'hFFFF; undefined build -> both read 0.
